// File: rtl/lcd_ctrl_pkg.sv
// Command codes and issuer FSM encodings shared by the LCD_CTRL command path.
package lcd_ctrl_pkg;

  localparam logic [3:0] WRITE       = 4'h0;
  localparam logic [3:0] SHIFT_UP    = 4'h1;
  localparam logic [3:0] SHIFT_DOWN  = 4'h2;
  localparam logic [3:0] SHIFT_LEFT  = 4'h3;
  localparam logic [3:0] SHIFT_RIGHT = 4'h4;
  localparam logic [3:0] MAX         = 4'h5;
  localparam logic [3:0] MIN         = 4'h6;
  localparam logic [3:0] AVERAGE     = 4'h7;
  localparam logic [3:0] ROT_CCW     = 4'h8;
  localparam logic [3:0] ROT_CW      = 4'h9;
  localparam logic [3:0] MIRROR_X    = 4'hA;
  localparam logic [3:0] MIRROR_Y    = 4'hB;

  // Anything above this code is dropped at the host interface.
  localparam logic [3:0] LAST_LEGAL_CMD = MIRROR_Y;

  typedef logic [1:0] issuer_state_t;
  localparam issuer_state_t ST_IDLE      = 2'd0;
  localparam issuer_state_t ST_GUARD     = 2'd1;
  localparam issuer_state_t ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/lcd_cmd_issuer_if.sv
// Host-side valid/ready command bus plus the LCD_CTRL cmd/busy/done handshake.
interface lcd_cmd_issuer_if #(
  parameter int CMD_W = 4
);
  logic [CMD_W-1:0] in_cmd;
  logic             in_valid;
  logic             in_ready;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_cmd, in_valid, busy, done,
    input  in_ready, cmd, cmd_valid
  );

  modport slave (
    input  in_cmd, in_valid, busy, done,
    output in_ready, cmd, cmd_valid
  );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for queued LCD commands; DEPTH must be a power of two.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Buffers host commands and issues them to LCD_CTRL one strobe at a time,
// holding off after a WRITE until LCD_CTRL reports done.
//
// state        | meaning
// IDLE         | may issue FIFO head when not busy
// GUARD        | one cycle after issue while LCD_CTRL raises busy
// WAIT_DONE    | WRITE issued, waiting for LCD_CTRL done
module lcd_cmd_issuer
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CMD_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  lcd_cmd_issuer_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   seq_done,
  output logic [3:0]             illegal_cnt
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  issuer_state_t    state;
  logic [CMD_W-1:0] head;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_valid_q;
  logic             accept;
  logic             legal;
  logic             push;
  logic             issue;

  assign bus.in_ready  = (level != FULL_LEVEL);
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign legal  = (bus.in_cmd <= CMD_W'(LAST_LEGAL_CMD));
  assign push   = accept & legal;
  assign issue  = (state == ST_IDLE) && (level != '0) && !bus.busy;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.in_cmd),
    .pop       (issue),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_cnt <= '0;
    end else if (accept && !legal && illegal_cnt != 4'hF) begin
      illegal_cnt <= illegal_cnt + 4'd1;
    end
  end

  // busy is not consulted in GUARD: LCD_CTRL only raises it an edge after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      seq_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            cmd_q       <= head;
            cmd_valid_q <= 1'b1;
            state       <= (head == CMD_W'(WRITE)) ? ST_WAIT_DONE : ST_GUARD;
          end
        end
        ST_GUARD: begin
          state <= ST_IDLE;
        end
        ST_WAIT_DONE: begin
          if (bus.done) begin
            seq_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_cmd_issuer.md
Name: lcd_cmd_issuer

Overview:
- Upstream command sequencer for LCD_CTRL.
- Accepts 4-bit image-processing commands from a host over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to LCD_CTRL as a one-cycle cmd/cmd_valid pulse, only when LCD_CTRL is not busy.
- Tracks the terminating Write command through to LCD_CTRL's done, replacing the bench-style "drive on !busy" driver with synthesizable logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CMD_W, 4, command width; must match LCD_CTRL cmd.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_cmd  input  CMD_W  host command.
- in_valid  input  1  host command valid.
- in_ready  output  1  FIFO can accept; equals (level != DEPTH).
- cmd  output  CMD_W  command to LCD_CTRL.
- cmd_valid  output  1  one-cycle issue strobe to LCD_CTRL.
- busy  input  1  LCD_CTRL busy.
- done  input  1  LCD_CTRL done pulse.
- level  output  log2(DEPTH)+1  FIFO occupancy.
- seq_done  output  1  one-cycle pulse on the edge after done is seen in WAIT_DONE.
- illegal_cnt  output  4  count of dropped illegal commands; saturates at 15.

Behaviour:
- Reset values: cmd=0, cmd_valid=0, level=0, seq_done=0, illegal_cnt=0, FIFO pointers=0, state=IDLE. in_ready=1 by derivation.
- Reset is honoured mid-operation: FIFO contents are discarded and the FSM returns to IDLE. A pending LCD_CTRL operation is not tracked after reset.
- Enqueue: in_valid & in_ready at posedge.
  - Legal codes 0x0–0xB are written to the FIFO.
  - Codes 0xC–0xF are dropped, illegal_cnt increments (saturating), and level is unchanged.
- Dequeue happens only on an ISSUE transition.
- Push and pop in the same edge: level unchanged, data ordering preserved.
- Push is impossible when full, because in_ready=0.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, GUARD, WAIT_DONE.
  - IDLE: if level!=0 and busy==0, then at the next edge:
    - cmd <= FIFO head; cmd_valid <= 1; pop.
    - If head==WRITE (0x0), go to WAIT_DONE; else go to GUARD.
  - GUARD: exactly one cycle.
    - cmd_valid <= 0; busy is ignored, because LCD_CTRL raises busy one edge after sampling cmd_valid.
    - Go to IDLE.
  - WAIT_DONE: cmd_valid <= 0; no issue.
    - On done==1, pulse seq_done and go to IDLE.
    - The host may keep enqueueing, so the next frame's commands queue up.
- Latency: a command accepted at edge t into an empty FIFO with busy low has cmd_valid high during cycle t+1..t+2.
- Minimum issue spacing is 2 cycles.
- cmd holds its last value while cmd_valid=0.
- A done outside WAIT_DONE is ignored.
- If the FIFO is empty in IDLE, the block remains idle with no output activity.

Decomposition:
- Package lcd_ctrl_pkg holds:
  - Command constants: WRITE=0x0, SHIFT_UP=0x1, SHIFT_DOWN=0x2, SHIFT_LEFT=0x3, SHIFT_RIGHT=0x4, MAX=0x5, MIN=0x6, AVERAGE=0x7, ROT_CCW=0x8, ROT_CW=0x9, MIRROR_X=0xA, MIRROR_Y=0xB.
  - LAST_LEGAL_CMD=0xB.
  - FSM state enum.
- One sub-module, cmd_fifo: synchronous FIFO with DEPTH/width parameters, push/pop, level output, async active-low reset.

Test Plan:
- Reset held low, then released → all outputs at reset values, in_ready=1, no cmd_valid for 10 cycles with in_valid=0.
- Push 0x3 with busy=0 → cmd=0x3, cmd_valid high exactly one cycle, one edge after acceptance; level returns to 0.
- Push 0x1,0x4,0x7; LCD_CTRL model raises busy for 3 cycles after each sample → three single-cycle strobes in order 1,4,7; none while busy=1 or in GUARD.
- Hold busy=1 and push 9 legal commands → in_ready drops after the 8th, level=8, 9th held by host; release busy → all 9 issued in order.
- Push 0xC, 0xF, then 0x2 → illegal_cnt=2, only 0x2 issued. Push 20 illegal codes → illegal_cnt saturates at 15.
- Push 0x5 then 0x0, with done asserted 6 cycles after the 0x0 strobe → no issue while in WAIT_DONE even if a queued 0x1 exists; seq_done pulses one cycle, then 0x1 is issued.
- Assert reset while level=4 and in WAIT_DONE → level=0, state IDLE, cmd_valid=0 immediately (asynchronous).
